spi_burst_bridge: RTL and testbench

//  Parametrised SPI slave -> TPU register/buffer bridge; successor to the single-byte SPI port.

---
 rtl/tpu_io_pkg.sv | 36 +++
 rtl/spi_edge_sync.sv | 53 +++++
 rtl/spi_burst_bridge.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_spi_burst_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_io_pkg.sv
// Shared definitions for the SPI burst bridge: command codes, FSM states,
// and bit positions inside err_flags and the STATUS word.
package tpu_io_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_START  = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_STAT,
        ST_DRAIN
    } state_e;

    localparam int ERR_OVERRUN  = 0;
    localparam int ERR_UNDERRUN = 1;
    localparam int ERR_WDOG     = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_OVERRUN  = 2;
    localparam int STAT_UNDERRUN = 3;
    localparam int STAT_WDOG     = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises the SPI pins into clk and resolves CPOL/CPHA into per-clk
// sample/shift strobes, all gated by the synchronised chip select.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 3,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_sclk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sample_edge,
    output logic shift_edge,
    output logic any_edge,
    output logic cs_active,
    output logic mosi_s
);

    localparam logic IDLE_LVL = (CPOL != 0);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;
    logic                   lead_edge;
    logic                   trail_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= {SYNC_STAGES{IDLE_LVL}};
            cs_q        <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= IDLE_LVL;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
            cs_q        <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    // All three pins share the same depth, so a CS release that lands with
    // an SCLK edge suppresses that edge here.
    assign cs_active   = ~cs_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_q[SYNC_STAGES-1];
    assign any_edge    = cs_active && (sclk_q[SYNC_STAGES-1] != sclk_prev_q);
    assign lead_edge   = any_edge && (sclk_prev_q == IDLE_LVL);
    assign trail_edge  = any_edge && (sclk_prev_q != IDLE_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;

endmodule

// File: rtl/spi_burst_bridge.sv
// SPI slave to TPU bus bridge with auto-incrementing bursts and sticky errors.
// Optional SCLK watchdog is built when SPI_WDOG_EN is defined.
module spi_burst_bridge
    import tpu_io_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_req,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  tpu_start,
    input  logic                  tpu_busy,
    input  logic                  tpu_done,
    output logic                  frame_active,
    output logic [2:0]            err_flags
);

    localparam int SHW   = max3(8, ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(SHW + 1);
    localparam int TXC_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TXC_W-1:0] TX_LAST   = TXC_W'(DATA_WIDTH - 1);

    logic sample_edge, shift_edge, any_edge, cs_active, mosi_s;

    state_e                state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SHW-2:0]        rx_q, rx_d;
    logic [SHW-1:0]        rx_word;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TXC_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
    logic                  rbuf_full_q, rbuf_full_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_req_q, rd_req_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  start_pend_q, start_pend_d;
    logic                  tpu_start_q, tpu_start_d;
    logic [2:0]            err_q, err_d;
    logic                  abort_q, abort_d;
    logic [DATA_WIDTH-1:0] status_word;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .CPOL        (CPOL),
        .CPHA        (CPHA)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .sample_edge (sample_edge),
        .shift_edge  (shift_edge),
        .any_edge    (any_edge),
        .cs_active   (cs_active),
        .mosi_s      (mosi_s)
    );

`ifdef SPI_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_cnt_q <= '0;
        else        wdog_cnt_q <= wdog_cnt_d;
    end
`else
    logic wdog_unused;
    assign wdog_unused = any_edge | (WDOG_CYCLES < 0);
`endif

    always_comb begin
        status_word                = '0;
        status_word[STAT_BUSY]     = tpu_busy;
        status_word[STAT_DONE]     = tpu_done;
        status_word[STAT_OVERRUN]  = err_q[ERR_OVERRUN];
        status_word[STAT_UNDERRUN] = err_q[ERR_UNDERRUN];
        status_word[STAT_WDOG]     = err_q[ERR_WDOG];
    end

    assign rx_word = {rx_q, mosi_s};

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        addr_d       = addr_q;
        tx_cnt_d     = tx_cnt_q;
        tx_d         = tx_q;
        rbuf_d       = rbuf_q;
        rbuf_full_d  = rbuf_full_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        start_pend_d = 1'b0;
        tpu_start_d  = start_pend_q;
        err_d        = err_q;
        abort_d      = abort_q;
`ifdef SPI_WDOG_EN
        wdog_cnt_d   = wdog_cnt_q;
`endif

        if (wr_valid_q && wr_ready) wr_valid_d = 1'b0;

        // Read data is only buffered while a read burst is streaming.
        if (state_q != ST_RDATA) begin
            rbuf_full_d = 1'b0;
        end else if (rd_valid) begin
            rbuf_d      = rd_data;
            rbuf_full_d = 1'b1;
        end

        if (sample_edge) begin
            rx_d      = rx_word[SHW-2:0];
            bit_cnt_d = bit_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (cs_active) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (sample_edge && bit_cnt_q == CMD_LAST) begin
                    bit_cnt_d = '0;
                    cmd_d     = rx_word[7:0];
                    case (rx_word[7:0])
                        CMD_WRITE, CMD_READ: state_d = ST_ADDR;
                        CMD_STATUS:          state_d = ST_STAT;
                        CMD_START: begin
                            state_d      = ST_DRAIN;
                            start_pend_d = 1'b1;
                        end
                        default:             state_d = ST_DRAIN;
                    endcase
                end
            end
            ST_ADDR: begin
                if (sample_edge && bit_cnt_q == ADDR_LAST) begin
                    bit_cnt_d = '0;
                    if (cmd_q == CMD_WRITE) begin
                        state_d = ST_WDATA;
                        addr_d  = rx_word[ADDR_WIDTH-1:0];
                    end else begin
                        state_d   = ST_RDATA;
                        rd_req_d  = 1'b1;
                        rd_addr_d = rx_word[ADDR_WIDTH-1:0];
                        addr_d    = rx_word[ADDR_WIDTH-1:0] + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (sample_edge && bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    if (wr_valid_d) begin
                        err_d[ERR_OVERRUN] = 1'b1;
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = rx_word[DATA_WIDTH-1:0];
                        addr_d     = addr_q + 1'b1;
                    end
                end
            end
            ST_RDATA: begin
                // Request the next word as soon as the current one is fully clocked.
                if (sample_edge && bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    rd_req_d  = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + 1'b1;
                end
            end
            ST_STAT: begin
                if (sample_edge && bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DRAIN;
                end
            end
            default: bit_cnt_d = '0;
        endcase

        // The shift edge that opens a word loads its MSB onto MISO; for CPHA=0
        // that is the trailing edge of the previous field's last bit.
        if (state_q == ST_RDATA || state_q == ST_STAT) begin
            if (shift_edge) begin
                tx_cnt_d = (tx_cnt_q == TX_LAST) ? '0 : tx_cnt_q + 1'b1;
                if (tx_cnt_q == '0) begin
                    if (state_q == ST_STAT) begin
                        tx_d  = status_word;
                        err_d = '0;
                    end else if (rbuf_full_q) begin
                        tx_d        = rbuf_q;
                        rbuf_full_d = 1'b0;
                    end else if (rd_valid) begin
                        tx_d        = rd_data;
                        rbuf_full_d = 1'b0;
                    end else begin
                        tx_d                = '0;
                        err_d[ERR_UNDERRUN] = 1'b1;
                    end
                end else begin
                    tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end else begin
            tx_d     = '0;
            tx_cnt_d = '0;
        end

`ifdef SPI_WDOG_EN
        if (!cs_active || any_edge || state_q == ST_IDLE || state_q == ST_DRAIN) begin
            wdog_cnt_d = '0;
        end else if (wdog_cnt_q == WD_LAST) begin
            wdog_cnt_d      = '0;
            state_d         = ST_DRAIN;
            bit_cnt_d       = '0;
            abort_d         = 1'b1;
            err_d[ERR_WDOG] = 1'b1;
        end else begin
            wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`else
        err_d[ERR_WDOG] = 1'b0;
`endif

        if (!cs_active) begin
            abort_d = 1'b0;
            if (state_q != ST_IDLE) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            addr_q       <= '0;
            tx_cnt_q     <= '0;
            tx_q         <= '0;
            rbuf_q       <= '0;
            rbuf_full_q  <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            start_pend_q <= 1'b0;
            tpu_start_q  <= 1'b0;
            err_q        <= '0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            addr_q       <= addr_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_q         <= tx_d;
            rbuf_q       <= rbuf_d;
            rbuf_full_q  <= rbuf_full_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            start_pend_q <= start_pend_d;
            tpu_start_q  <= tpu_start_d;
            err_q        <= err_d;
            abort_q      <= abort_d;
        end
    end

    assign spi_miso     = tx_q[DATA_WIDTH-1];
    assign spi_miso_oe  = cs_active;
    assign wr_valid     = wr_valid_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign rd_req       = rd_req_q;
    assign rd_addr      = rd_addr_q;
    assign tpu_start    = tpu_start_q;
    assign frame_active = cs_active & ~abort_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_spi_burst_bridge.sv
// Directed bench for spi_burst_bridge: a mode-0 instance and a mode-3 instance
// driven by a bit-banged SPI master, with a 2-cycle-latency read responder.
module tb_spi_burst_bridge;

    localparam int HALF = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic mosi = 1'b0;
    logic tpu_busy = 1'b0;
    logic tpu_done = 1'b0;

    // Mode 0 instance signals
    logic       sclk0 = 1'b0, cs0_n = 1'b1, wr_ready0 = 1'b1, rd_valid0 = 1'b0;
    logic [7:0] rd_data0 = 8'h00;
    logic       miso0, miso_oe0, wr_valid0, rd_req0, tpu_start0, frame_active0;
    logic [7:0] wr_addr0, wr_data0, rd_addr0;
    logic [2:0] err0;

    // Mode 3 instance signals
    logic       sclk3 = 1'b1, cs3_n = 1'b1, wr_ready3 = 1'b1;
    logic       rd_valid3 = 1'b0;
    logic [7:0] rd_data3 = 8'h00;
    logic       miso3, miso_oe3, wr_valid3, rd_req3, tpu_start3, frame_active3;
    logic [7:0] wr_addr3, wr_data3, rd_addr3;
    logic [2:0] err3;

    int tests = 0;
    int fails = 0;

    spi_burst_bridge #(.CPOL(0), .CPHA(0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk0), .spi_cs_n(cs0_n), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(miso_oe0), .wr_valid(wr_valid0), .wr_ready(wr_ready0),
        .wr_addr(wr_addr0), .wr_data(wr_data0), .rd_req(rd_req0), .rd_addr(rd_addr0),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .tpu_start(tpu_start0), .tpu_busy(tpu_busy),
        .tpu_done(tpu_done), .frame_active(frame_active0), .err_flags(err0)
    );

    spi_burst_bridge #(.CPOL(1), .CPHA(1)) u_m3 (
        .clk(clk), .rst_n(rst_n), .spi_sclk(sclk3), .spi_cs_n(cs3_n), .spi_mosi(mosi),
        .spi_miso(miso3), .spi_miso_oe(miso_oe3), .wr_valid(wr_valid3), .wr_ready(wr_ready3),
        .wr_addr(wr_addr3), .wr_data(wr_data3), .rd_req(rd_req3), .rd_addr(rd_addr3),
        .rd_valid(rd_valid3), .rd_data(rd_data3), .tpu_start(tpu_start3), .tpu_busy(tpu_busy),
        .tpu_done(tpu_done), .frame_active(frame_active3), .err_flags(err3)
    );

    // TPU-side models: read responder, write acceptance log, start pulse counter
    logic [7:0]  mem [256];
    logic        req_p1 = 1'b0;
    logic [7:0]  raddr_p1 = 8'h00;
    logic [7:0]  rdlog [$];
    logic [15:0] wrlog [$];
    int          start_cnt = 0;

    always @(posedge clk) begin
        req_p1    <= rd_req3;
        raddr_p1  <= rd_addr3;
        rd_valid3 <= req_p1;
        rd_data3  <= mem[raddr_p1];
        if (rd_req3) rdlog.push_back(rd_addr3);
        if (wr_valid0 && wr_ready0) wrlog.push_back({wr_addr0, wr_data0});
        if (tpu_start0) start_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cs_start(input int m);
        if (m == 0) cs0_n = 1'b0; else cs3_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_end(input int m);
        #(HALF);
        if (m == 0) cs0_n = 1'b1; else cs3_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_bits(input int m, input int n, input logic [31:0] tx, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (m == 0) begin
                mosi = tx[i];
                #(HALF);
                rx = {rx[30:0], miso0};
                sclk0 = 1'b1;
                #(HALF);
                sclk0 = 1'b0;
            end else begin
                sclk3 = 1'b0;
                mosi = tx[i];
                #(HALF);
                rx = {rx[30:0], miso3};
                sclk3 = 1'b1;
                #(HALF);
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #(20);
        rst_n = 1'b1;
        #(20);
    endtask

    initial begin
        logic [31:0] rx;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'hFF] = 8'h5A;
        mem[8'h00] = 8'hC3;
        mem[8'h01] = 8'h77;

        // Reset state
        #(20);
        chk("rst_wr_valid", {31'd0, wr_valid0}, 32'd0);
        chk("rst_rd_req", {31'd0, rd_req0}, 32'd0);
        chk("rst_tpu_start", {31'd0, tpu_start0}, 32'd0);
        chk("rst_err", {29'd0, err0}, 32'd0);
        chk("rst_frame_active", {31'd0, frame_active0}, 32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe0}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr0}, 32'd0);
        rst_n = 1'b1;
        #(40);

        // Mode 0 write burst with wr_ready held high
        cs_start(0);
        chk("frame_active_on", {31'd0, frame_active0}, 32'd1);
        chk("miso_oe_on", {31'd0, miso_oe0}, 32'd1);
        spi_bits(0, 8, 32'h01, rx);
        spi_bits(0, 8, 32'h10, rx);
        spi_bits(0, 8, 32'hA5, rx);
        spi_bits(0, 8, 32'h3C, rx);
        cs_end(0);
        chk("wr_count", wrlog.size(), 32'd2);
        chk("wr0", {16'd0, wrlog[0]}, 32'h10A5);
        chk("wr1", {16'd0, wrlog[1]}, 32'h113C);
        chk("wr_flags", {29'd0, err0}, 32'd0);
        chk("frame_active_off", {31'd0, frame_active0}, 32'd0);

        // Write overrun: first word held, second dropped
        wr_ready0 = 1'b0;
        cs_start(0);
        spi_bits(0, 8, 32'h01, rx);
        spi_bits(0, 8, 32'h20, rx);
        spi_bits(0, 8, 32'h11, rx);
        spi_bits(0, 8, 32'h22, rx);
        cs_end(0);
        chk("ovr_wr_valid", {31'd0, wr_valid0}, 32'd1);
        chk("ovr_wr_addr", {24'd0, wr_addr0}, 32'h20);
        chk("ovr_wr_data", {24'd0, wr_data0}, 32'h11);
        chk("ovr_flags", {29'd0, err0}, 32'b001);
        wr_ready0 = 1'b1;
        #(50);
        chk("ovr_wr_count", wrlog.size(), 32'd3);
        chk("ovr_wr_accept", {16'd0, wrlog[2]}, 32'h2011);
        chk("ovr_wr_valid_clr", {31'd0, wr_valid0}, 32'd0);

        pulse_reset();
        chk("reset_clears_flags", {29'd0, err0}, 32'd0);

        // Read underrun with rd_valid withheld, then STATUS read
        cs_start(0);
        spi_bits(0, 8, 32'h02, rx);
        spi_bits(0, 8, 32'h40, rx);
        spi_bits(0, 8, 32'h00, rx);
        cs_end(0);
        chk("udr_miso_word", rx, 32'h00);
        chk("udr_flags", {29'd0, err0}, 32'b010);
        tpu_done = 1'b1;
        cs_start(0);
        spi_bits(0, 8, 32'h04, rx);
        spi_bits(0, 8, 32'h00, rx);
        cs_end(0);
        chk("status_word", rx, 32'h0A);
        chk("status_clears_flags", {29'd0, err0}, 32'd0);
        tpu_done = 1'b0;

        // START command produces exactly one single-cycle pulse
        start_cnt = 0;
        cs_start(0);
        spi_bits(0, 8, 32'h03, rx);
        cs_end(0);
        chk("start_pulse_cycles", start_cnt, 32'd1);

        // CS raised mid-word: partial word discarded
        cs_start(0);
        spi_bits(0, 8, 32'h01, rx);
        spi_bits(0, 8, 32'h30, rx);
        spi_bits(0, 5, 32'h15, rx);
        cs_end(0);
        chk("partial_wr_valid", {31'd0, wr_valid0}, 32'd0);
        chk("partial_wr_count", wrlog.size(), 32'd3);
        chk("partial_flags", {29'd0, err0}, 32'd0);

        // Mode 3 read burst wrapping from 0xFF to 0x00
        cs_start(3);
        spi_bits(3, 8, 32'h02, rx);
        spi_bits(3, 8, 32'hFF, rx);
        spi_bits(3, 16, 32'h0000, rx);
        cs_end(3);
        chk("m3_word0", {24'd0, rx[15:8]}, 32'h5A);
        chk("m3_word1", {24'd0, rx[7:0]}, 32'hC3);
        chk("m3_rd_addr0", {24'd0, rdlog[0]}, 32'hFF);
        chk("m3_rd_addr1", {24'd0, rdlog[1]}, 32'h00);
        chk("m3_flags", {29'd0, err3}, 32'd0);

`ifdef SPI_WDOG_EN
        // SCLK stalls with CS held low
        cs_start(0);
        spi_bits(0, 3, 32'h0, rx);
        #((4096 + 100) * 10);
        chk("wdog_frame_active", {31'd0, frame_active0}, 32'd0);
        chk("wdog_flag", {31'd0, err0[2]}, 32'd1);
        cs_end(0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
